iterative_shifter: RTL and testbench
====================================

# iterative_shifter

Parametrised multi-cycle shifter: accepts a WIDTH-bit operand, a shift amount and a mode, then shifts one bit position per clock until done. Generalises the fixed 10-bit, one-position arithmetic right shift to arbitrary width, variable amount and multiple modes, with a start/busy/done handshake. Sits beside the ALU datapath; it is used where a full barrel shifter is too costly and multi-cycle latency is acceptable.

## Interface
- `WIDTH`, 10: operand and result width in bits, ≥ 2.
- `SHAMT_W`, 4: shift-amount width; must satisfy 2^SHAMT_W > WIDTH.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; accepted only when `busy`=0.
- `mode`  input  2  operation select, sampled at accept: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right (see Configuration).
- `shamt`  input  SHAMT_W  shift amount, unsigned, sampled at accept.
- `in_data`  input  WIDTH  operand, sampled at accept.
- `busy`  output  1  operation in progress.
- `done`  output  1  single-cycle pulse; `out_data` is final.
- `out_data`  output  WIDTH  result register.

## Operation
- Internal state:
  - data register, which drives `out_data`;
  - down-counter `cnt` (SHAMT_W bits);
  - latched mode;
  - `busy` and `done` flops.
- Two implicit states, IDLE (`busy`=0) and RUN (`busy`=1).
- **Accept:** `start`=1 while `busy`=0. At that edge:
  - data ← `in_data`;
  - `cnt` ← effective amount;
  - mode is latched;
  - `busy` ← 1, `done` ← 0.
- **Effective amount:**
  - modes 00/01/10: min(`shamt`, WIDTH). Amounts ≥ WIDTH give all-zero for logical shifts and all-sign-bit for the arithmetic right shift.
  - rotate: `shamt` unmodified, so a rotate takes up to 2^SHAMT_W−1 steps.
- **RUN with `cnt`≠0:** each edge performs one step and decrements `cnt`.
  - logical left: data ← {data[WIDTH-2:0], 0}.
  - logical right: data ← {0, data[WIDTH-1:1]}.
  - arithmetic right: data ← {data[WIDTH-1], data[WIDTH-1:1]}.
  - rotate right: data ← {data[0], data[WIDTH-1:1]}.
- **RUN with `cnt`=0:** next edge sets `busy` ← 0 and `done` ← 1. Data is unchanged.
- **`done`:** high for exactly one cycle, then clears unless a new completion occurs.
- **`start` while `busy`=1:** ignored, with no effect on the operation in flight.
- **`start` in the `done` cycle:** accepted, since `busy` is already 0. Back-to-back operations therefore have no bubble beyond the completion cycle.
- **`out_data` validity:**
  - holds intermediate values while `busy`=1;
  - is valid from the `done` cycle until the next accept;
  - holds its value indefinitely in IDLE.
- **Reset:** valid at any time, including mid-operation. It aborts the operation and clears `busy`=0, `done`=0, `out_data`=0, `cnt`=0; no `done` is produced for the aborted operation.

## Timing
- Accept occurs at edge E0.
- `busy` is high from E0 until E(n+1), where n is the effective amount.
- `done` is high during the cycle after E(n+1).
- Latency from accept to `done` is n+1 clocks: `shamt`=0 gives 1 clock; a saturated shift with WIDTH=10 gives 11 clocks.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Reset is asynchronous on assertion; the release must be synchronised externally.

## Configuration
- **Macro `ITERATIVE_SHIFTER_ROTATE_EN`.**
- **Defined:**
  - `mode`=11 is rotate right, with the effective amount equal to the raw `shamt`;
  - `cnt` compare logic for the uncapped amount is present.
- **Undefined:**
  - no rotate datapath is built;
  - `mode`=11 behaves exactly as 10 (arithmetic right), including saturation to WIDTH.

## Test plan
- WIDTH=10, mode 10, `in_data`=10'b1000000100, `shamt`=1 → `out_data`=10'b1100000010; `done` 2 clocks after accept; `busy` high for 2 cycles.
- Mode 00, `in_data`=0x0F3, `shamt`=4 → 0x330 with latency 5. Mode 01, `in_data`=0x3FF, `shamt`=0 → 0x3FF with latency 1.
- Mode 10, `in_data`=0x200, `shamt`=15 → 0x3FF after 11 clocks. Mode 01, same operand and amount → 0x000.
- Mode 11, `in_data`=0x001, `shamt`=3:
  - with macro → 0x080, latency 4;
  - without macro → 0x000.
- Issue mode 00, `shamt`=5; pulse `start` at cycle 2 with different operands → ignored, first result intact. Assert `start` in the `done` cycle → new operation accepted the same cycle.
- Assert `rst` at cycle 3 of a 9-step operation → `busy`, `done` and `out_data` are 0 immediately, with no `done` pulse afterwards. After release, a new operation completes normally.

Source files
------------

// File: rtl/iterative_shifter_if.sv
// Handshake and data bundle for iterative_shifter.
// master drives the request side, slave (the shifter) drives status and result.
interface iterative_shifter_if #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned SHAMT_W = 4
);
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   in_data;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output start, mode, shamt, in_data,
    input  busy, done, out_data
  );

  modport slave (
    input  start, mode, shamt, in_data,
    output busy, done, out_data
  );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one bit position per clock, start/busy/done handshake.
// Modes: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
// Optional feature macro ITERATIVE_SHIFTER_ROTATE_EN: when defined, mode 11 is a
// rotate right by the raw shamt; when undefined, mode 11 behaves exactly as mode 10.
module iterative_shifter #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned SHAMT_W = 4
) (
  input logic               clk,
  input logic               rst,
  iterative_shifter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Saturation point for the capped shift modes; fits because 2^SHAMT_W > WIDTH.
  localparam logic [SHAMT_W-1:0] WidthAmt = SHAMT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] eff_amt;
  logic [1:0]         mode_in;
  logic [WIDTH-1:0]   step_data;

  // Resolve the amount and mode that get latched on accept.
  always_comb begin
    mode_in = bus.mode;
    eff_amt = (bus.shamt > WidthAmt) ? WidthAmt : bus.shamt;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    // Rotation is periodic, so the amount is left uncapped.
    if (bus.mode == 2'b11) begin
      eff_amt = bus.shamt;
    end
`else
    // No rotate datapath: fold mode 11 onto arithmetic right.
    if (bus.mode == 2'b11) begin
      mode_in = 2'b10;
    end
`endif
  end

  // Single-position step for the latched mode.
  always_comb begin
    step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
    case (mode_q)
      2'b00:   step_data = {data_q[WIDTH-2:0], 1'b0};
      2'b01:   step_data = {1'b0, data_q[WIDTH-1:1]};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      2'b11:   step_data = {data_q[0], data_q[WIDTH-1:1]};
`endif
      default: step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
    endcase
  end

  // Next-state: accept in idle, step while cnt is nonzero, then complete.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          data_d  = bus.in_data;
          cnt_d   = eff_amt;
          mode_d  = mode_in;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          data_d = step_data;
          cnt_d  = cnt_q - SHAMT_W'(1);
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Registered outputs only.
  always_comb begin
    bus.busy     = (state_q == StRun);
    bus.done     = done_q;
    bus.out_data = data_q;
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter (WIDTH=10, SHAMT_W=4).
module tb_iterative_shifter;

  logic clk;
  logic rst;

  iterative_shifter_if #(.WIDTH(10), .SHAMT_W(4)) bus ();

  iterative_shifter #(.WIDTH(10), .SHAMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] shamt;
    logic [9:0] din;
    logic [9:0] dout;
    int         lat;
  } vec_t;

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts edges until done is seen (sampled 1 time unit after each edge).
  // busy_cnt counts busy samples, including the one just before the first edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Drives a request on the falling edge and returns 1 time unit after the accept edge.
  task automatic issue(input logic [1:0] m, input logic [3:0] s, input logic [9:0] d);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.shamt   = s;
    bus.in_data = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    logic [9:0] res;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{2'b10, 4'd1,  10'h204, 10'h302, 2};
    vecs[1] = '{2'b00, 4'd4,  10'h0F3, 10'h330, 5};
    vecs[2] = '{2'b01, 4'd0,  10'h3FF, 10'h3FF, 1};
    vecs[3] = '{2'b10, 4'd15, 10'h200, 10'h3FF, 11};
    vecs[4] = '{2'b01, 4'd15, 10'h200, 10'h000, 11};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    vecs[5] = '{2'b11, 4'd3,  10'h001, 10'h080, 4};
    vecs[6] = '{2'b11, 4'd12, 10'h003, 10'h300, 13};
`else
    vecs[5] = '{2'b11, 4'd3,  10'h001, 10'h000, 4};
    vecs[6] = '{2'b11, 4'd12, 10'h003, 10'h000, 11};
`endif
    vecs[7] = '{2'b00, 4'd10, 10'h3FF, 10'h000, 11};
    vecs[8] = '{2'b10, 4'd3,  10'h3F0, 10'h3FE, 4};
    vecs[9] = '{2'b01, 4'd9,  10'h3FF, 10'h001, 10};

    bus.start   = 1'b0;
    bus.mode    = 2'b00;
    bus.shamt   = 4'd0;
    bus.in_data = 10'h000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].mode, vecs[i].shamt, vecs[i].din);
      check($sformatf("v%0d busy at accept", i), 32'(bus.busy), 32'd1);
      wait_done(lat, bcnt);
      res = bus.out_data;
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].lat));
      check($sformatf("v%0d result", i), 32'(res), 32'(vecs[i].dout));
      check($sformatf("v%0d busy in done cycle", i), 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d done one cycle", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d out_data held", i), 32'(bus.out_data), 32'(vecs[i].dout));
    end

    // start while busy is ignored.
    issue(2'b00, 4'd5, 10'h001);
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.mode    = 2'b01;
    bus.shamt   = 4'd1;
    bus.in_data = 10'h3FF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check("ignored start latency", 32'(lat), 32'd4);
    check("ignored start result", 32'(bus.out_data), 32'h020);

    // start in the done cycle is accepted at the next edge.
    bus.start   = 1'b1;
    bus.mode    = 2'b01;
    bus.shamt   = 4'd2;
    bus.in_data = 10'h3FF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("done-cycle accept busy", 32'(bus.busy), 32'd1);
    check("done-cycle accept done low", 32'(bus.done), 32'd0);
    wait_done(lat, bcnt);
    check("back-to-back latency", 32'(lat), 32'd3);
    check("back-to-back result", 32'(bus.out_data), 32'h0FF);

    // Asynchronous reset mid-operation.
    issue(2'b00, 4'd9, 10'h001);
    repeat (3) @(posedge clk);
    #2;
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset done", 32'(bus.done), 32'd0);
    check("async reset out_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    check("no activity after abort", 32'(dcnt), 32'd0);
    issue(2'b10, 4'd2, 10'h200);
    wait_done(lat, bcnt);
    check("post-reset latency", 32'(lat), 32'd3);
    check("post-reset result", 32'(bus.out_data), 32'h380);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
